// File: rtl/svc_axi_pkg.sv
// Shared types for the AXI read-path blocks: arbiter FSM states and AXI encodings.
// Pure declarations; no logic, so no latency or flow-control behaviour.
package svc_axi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } arb_state_t;

   localparam int AXI_LEN_WIDTH = 8;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/svc_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from the last winner.
// Zero-latency grant; the priority pointer only moves when the owner signals done.
module svc_rr_arbiter #(
   parameter int N = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 done,
   input  logic [$clog2(N)-1:0] done_idx,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_vld
);

   localparam int IXW = $clog2(N);

   logic [IXW-1:0] ptr;
   logic [IXW-1:0] cand;

   // Pointer holds the last winner, so after reset master 0 is searched first.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr <= IXW'(N - 1);
      end else if (done) begin
         ptr <= done_idx;
      end
   end

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      cand    = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IXW'((int'(ptr) + k) % N);
         if (!gnt_vld && req[cand]) begin
            gnt_vld   = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/svc_axi_rd_arbiter.sv
// N-way AXI4 read arbiter: one burst in flight, AR registered (1 cycle), R routed combinationally.
// Backpressure: slave AR stall holds the registered AR; R stalls pass straight through to the granted master.
module svc_axi_rd_arbiter
   import svc_axi_pkg::*;
#(
   parameter int NUM_M          = 2,
   parameter int AXI_ADDR_WIDTH = 12,
   parameter int AXI_DATA_WIDTH = 128,
   parameter int AXI_ID_WIDTH   = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_M-1:0]                  s_axi_arvalid,
   input  logic [NUM_M*AXI_ID_WIDTH-1:0]     s_axi_arid,
   input  logic [NUM_M*AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [NUM_M*AXI_LEN_WIDTH-1:0]    s_axi_arlen,
   input  logic [NUM_M*3-1:0]                s_axi_arsize,
   input  logic [NUM_M*2-1:0]                s_axi_arburst,
   output logic [NUM_M-1:0]                  s_axi_arready,
   output logic [NUM_M-1:0]                  s_axi_rvalid,
   output logic [AXI_ID_WIDTH-1:0]           s_axi_rid,
   output logic [AXI_DATA_WIDTH-1:0]         s_axi_rdata,
   output logic [1:0]                        s_axi_rresp,
   output logic                              s_axi_rlast,
   input  logic [NUM_M-1:0]                  s_axi_rready,
   output logic                              m_axi_arvalid,
   output logic [AXI_ID_WIDTH-1:0]           m_axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
   output logic [AXI_LEN_WIDTH-1:0]          m_axi_arlen,
   output logic [2:0]                        m_axi_arsize,
   output logic [1:0]                        m_axi_arburst,
   input  logic                              m_axi_arready,
   input  logic                              m_axi_rvalid,
   input  logic [AXI_ID_WIDTH-1:0]           m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]         m_axi_rdata,
   input  logic [1:0]                        m_axi_rresp,
   input  logic                              m_axi_rlast,
   output logic                              m_axi_rready
);

   localparam int IW  = AXI_ID_WIDTH;
   localparam int AW  = AXI_ADDR_WIDTH;
   localparam int LW  = AXI_LEN_WIDTH;
   localparam int IXW = $clog2(NUM_M);

   arb_state_t state, state_nxt;

   logic [IXW-1:0]   grant_q;
   logic [LW-1:0]    beat_cnt;
   logic [NUM_M-1:0] arb_gnt;
   logic [IXW-1:0]   arb_idx;
   logic             arb_vld;
   logic             ar_take;
   logic             r_hs;
   logic             burst_done;

   logic [IW-1:0]    sel_id;
   logic [AW-1:0]    sel_addr;
   logic [LW-1:0]    sel_len;
   logic [2:0]       sel_size;
   logic [1:0]       sel_burst;

   svc_rr_arbiter #(.N(NUM_M)) u_rr (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (s_axi_arvalid),
      .done     (burst_done),
      .done_idx (grant_q),
      .gnt      (arb_gnt),
      .gnt_idx  (arb_idx),
      .gnt_vld  (arb_vld)
   );

   always_comb begin
      sel_id    = '0;
      sel_addr  = '0;
      sel_len   = '0;
      sel_size  = '0;
      sel_burst = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (arb_idx == IXW'(i)) begin
            sel_id    = s_axi_arid[i*IW +: IW];
            sel_addr  = s_axi_araddr[i*AW +: AW];
            sel_len   = s_axi_arlen[i*LW +: LW];
            sel_size  = s_axi_arsize[i*3 +: 3];
            sel_burst = s_axi_arburst[i*2 +: 2];
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      s_axi_arready = '0;
      s_axi_rvalid  = '0;
      m_axi_rready  = 1'b0;
      s_axi_rid     = '0;
      s_axi_rdata   = '0;
      s_axi_rresp   = '0;
      s_axi_rlast   = 1'b0;
      ar_take       = 1'b0;
      r_hs          = 1'b0;
      burst_done    = 1'b0;
      case (state)
         IDLE: begin
            s_axi_arready = arb_gnt;
            ar_take       = arb_vld;
            if (arb_vld) state_nxt = ADDR;
         end
         ADDR: begin
            if (m_axi_arvalid && m_axi_arready) state_nxt = DATA;
         end
         DATA: begin
            for (int i = 0; i < NUM_M; i++) begin
               s_axi_rvalid[i] = m_axi_rvalid && (grant_q == IXW'(i));
            end
            m_axi_rready = s_axi_rready[grant_q];
            s_axi_rid    = m_axi_rid;
            s_axi_rdata  = m_axi_rdata;
            s_axi_rresp  = m_axi_rresp;
            s_axi_rlast  = m_axi_rlast;
            r_hs         = m_axi_rvalid && s_axi_rready[grant_q];
            // Beat count also closes the burst so a slave that drops RLAST cannot wedge the port.
            burst_done   = r_hs && (m_axi_rlast || (beat_cnt == m_axi_arlen));
            if (burst_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         grant_q       <= '0;
         beat_cnt      <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_arid    <= '0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
         m_axi_arsize  <= '0;
         m_axi_arburst <= '0;
      end else begin
         state <= state_nxt;
         if (ar_take) begin
            grant_q       <= arb_idx;
            beat_cnt      <= '0;
            m_axi_arvalid <= 1'b1;
            m_axi_arid    <= sel_id;
            m_axi_araddr  <= sel_addr;
            m_axi_arlen   <= sel_len;
            m_axi_arsize  <= sel_size;
            m_axi_arburst <= sel_burst;
         end else if (state == ADDR && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
         end
         if (r_hs) beat_cnt <= beat_cnt + LW'(1);
      end
   end

`ifdef FORMAL
   always @(posedge clk) begin
      if (rst_n) begin
         if (state == DATA && m_axi_rvalid) assert (m_axi_rlast == (beat_cnt == m_axi_arlen));
         assert (state == DATA || !m_axi_rvalid);
         assert ($onehot0(s_axi_rvalid));
      end
   end
`endif

endmodule

// File: tb/tb_svc_axi_rd_arbiter.sv
// Bench for svc_axi_rd_arbiter: random masters/slave against a transaction-level arbiter model.
module tb_svc_axi_rd_arbiter;

   localparam int N  = 2;
   localparam int AW = 12;
   localparam int DW = 128;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n = 1'b0;
   logic [N-1:0]     s_arvalid = '0;
   logic [N*IW-1:0]  s_arid = '0;
   logic [N*AW-1:0]  s_araddr = '0;
   logic [N*8-1:0]   s_arlen = '0;
   logic [N*3-1:0]   s_arsize = '0;
   logic [N*2-1:0]   s_arburst = '0;
   logic [N-1:0]     s_rready = '0;
   logic             m_arready = 1'b0;
   logic             m_rvalid = 1'b0;
   logic [IW-1:0]    m_rid = '0;
   logic [DW-1:0]    m_rdata = '0;
   logic [1:0]       m_rresp = '0;
   logic             m_rlast = 1'b0;

   logic [N-1:0]     s_axi_arready, s_axi_rvalid;
   logic [IW-1:0]    s_axi_rid;
   logic [DW-1:0]    s_axi_rdata;
   logic [1:0]       s_axi_rresp;
   logic             s_axi_rlast;
   logic             m_axi_arvalid, m_axi_rready;
   logic [IW-1:0]    m_axi_arid;
   logic [AW-1:0]    m_axi_araddr;
   logic [7:0]       m_axi_arlen;
   logic [2:0]       m_axi_arsize;
   logic [1:0]       m_axi_arburst;

   svc_axi_rd_arbiter #(.NUM_M(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_arvalid(s_arvalid), .s_axi_arid(s_arid), .s_axi_araddr(s_araddr),
      .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst),
      .s_axi_arready(s_axi_arready), .s_axi_rvalid(s_axi_rvalid), .s_axi_rid(s_axi_rid),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
      .s_axi_rready(s_rready),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr),
      .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arready(m_arready),
      .m_axi_rvalid(m_rvalid), .m_axi_rid(m_rid), .m_axi_rdata(m_rdata),
      .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast), .m_axi_rready(m_axi_rready)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- stimulus: random masters and a well-behaved slave ----------------
   typedef struct {logic [IW-1:0] id; logic [7:0] len;} burst_t;
   burst_t       arq[$];
   burst_t       cur;
   bit           cur_act = 0;
   int           beat = 0;
   logic [DW-1:0] sent[$];
   logic [DW-1:0] rcv[$];
   int           dut_log[$];

   bit auto_req = 0, auto_rrdy = 0, auto_arrdy = 0;
   int p_req = 0, p_rrdy = 0, p_arrdy = 0, p_rvld = 0;

   logic [N-1:0] hs_ar = '0;
   logic         hs_mar = 1'b0, hs_r = 1'b0;
   logic [IW-1:0] mar_id = '0;
   logic [7:0]   mar_len = '0;

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] l);
      s_arvalid[i]           = 1'b1;
      s_arid[i*IW +: IW]     = IW'(i);
      s_araddr[i*AW +: AW]   = a;
      s_arlen[i*8 +: 8]      = l;
      s_arsize[i*3 +: 3]     = 3'd4;
      s_arburst[i*2 +: 2]    = 2'b01;
   endtask

   task automatic clr_inputs();
      s_arvalid = '0; s_rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
      arq.delete(); cur_act = 0; beat = 0;
   endtask

   task automatic drive();
      if (!rst_n) return;
      for (int i = 0; i < N; i++) begin
         if (hs_ar[i]) s_arvalid[i] = 1'b0;
         if (!s_arvalid[i] && auto_req && $urandom_range(99) < p_req)
            set_req(i, AW'($urandom), 8'($urandom_range(3)));
         if (auto_rrdy) s_rready[i] = ($urandom_range(99) < p_rrdy);
      end
      if (hs_mar) arq.push_back('{mar_id, mar_len});
      if (hs_r) begin
         sent.push_back(m_rdata);
         m_rvalid = 1'b0;
         if (m_rlast) cur_act = 0;
         else beat++;
      end
      if (auto_arrdy) m_arready = ($urandom_range(99) < p_arrdy);
      if (!cur_act && arq.size() > 0) begin
         cur = arq.pop_front(); cur_act = 1; beat = 0;
      end
      if (cur_act && !m_rvalid && $urandom_range(99) < p_rvld) begin
         m_rvalid = 1'b1;
         m_rid    = cur.id;
         m_rdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
         m_rresp  = 2'($urandom_range(3));
         m_rlast  = (beat == int'(cur.len));
      end
   endtask

   // Handshakes as they will be seen by the coming clock edge.
   always @(negedge clk) begin
      #2;
      for (int i = 0; i < N; i++) begin
         hs_ar[i] = s_arvalid[i] && s_axi_arready[i];
         if (hs_ar[i]) dut_log.push_back(i);
      end
      hs_mar  = m_axi_arvalid && m_arready;
      mar_id  = m_axi_arid;
      mar_len = m_axi_arlen;
      hs_r    = m_rvalid && m_axi_rready;
   end

   // ---------------- reference model: owner / phase / last winner ----------------
   int           m_phase = 0;   // 0 free, 1 request forwarded, 2 data returning
   int           m_last  = N - 1;
   int           m_owner = 0;
   logic [26:0]  m_ar    = '0;

   function automatic int winner(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [26:0] payload(input int i);
      return {s_arid[i*IW +: IW], s_araddr[i*AW +: AW], s_arlen[i*8 +: 8],
              s_arsize[i*3 +: 3], s_arburst[i*2 +: 2]};
   endfunction

   always @(negedge clk) begin
      int           w;
      logic [N-1:0] e_arrdy, e_rv;
      #1;
      w = winner(s_arvalid, m_last);
      e_arrdy = '0;
      e_rv    = '0;
      if (m_phase == 0 && w >= 0) e_arrdy[w] = 1'b1;
      if (m_phase == 2 && m_rvalid) e_rv[m_owner] = 1'b1;
      chk("s_axi_arready", s_axi_arready, e_arrdy);
      chk("m_axi_arvalid", m_axi_arvalid, m_phase == 1);
      chk("m_axi_ar_payload", {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst}, m_ar);
      chk("s_axi_rvalid", s_axi_rvalid, e_rv);
      chk("m_axi_rready", m_axi_rready, (m_phase == 2) && s_rready[m_owner]);
      if (m_phase == 2)
         chk("r_broadcast", {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast},
             {m_rid, m_rdata, m_rresp, m_rlast});
      if (!rst_n) begin
         m_phase = 0; m_last = N - 1; m_ar = '0;
      end else begin
         case (m_phase)
            0: if (w >= 0) begin m_owner = w; m_ar = payload(w); m_phase = 1; end
            1: if (m_arready) m_phase = 2;
            default: if (m_rvalid && s_rready[m_owner] && m_rlast) begin
               m_last = m_owner; m_phase = 0;
            end
         endcase
      end
   end

   // ---------------- sequencing helpers ----------------
   task automatic step();
      @(negedge clk);
      drive();
   endtask

   task automatic set_easy();
      auto_arrdy = 1; p_arrdy = 100; auto_rrdy = 1; p_rrdy = 100; p_rvld = 100;
   endtask

   task automatic reset_dut();
      step();
      rst_n = 1'b0;
      clr_inputs();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string nm);
      int k;
      for (k = 0; k < 400; k++) begin
         if (s_arvalid == '0 && m_phase == 0 && !cur_act && arq.size() == 0 && !m_rvalid) break;
         step();
      end
      chk(nm, k < 400, 1'b1);
   endtask

   int exp_order[6] = '{0, 1, 0, 1, 0, 1};

   initial begin
      int got0, bad1, got, hold, k;
      bit hold_now;
      clr_inputs();
      repeat (3) step();
      rst_n = 1'b1;

      // Quiet after reset
      for (int c = 0; c < 10; c++) begin
         step(); #3;
         chk("idle_arvalid", m_axi_arvalid, 1'b0);
         chk("idle_outputs", {s_axi_arready, s_axi_rvalid, m_axi_rready, m_axi_araddr, s_axi_rdata}, '0);
      end

      // Single two-beat read from M0
      step();
      set_easy();
      set_req(0, 12'h020, 8'd1);
      step(); #3;
      chk("t2_arvalid", m_axi_arvalid, 1'b1);
      chk("t2_araddr", m_axi_araddr, 12'h020);
      got0 = 0; bad1 = 0;
      for (int c = 0; c < 12; c++) begin
         step(); #3;
         if (s_axi_rvalid[0] && s_rready[0]) got0++;
         if (s_axi_rvalid[1]) bad1++;
      end
      chk("t2_beats_m0", got0, 2);
      chk("t2_beats_m1", bad1, 0);

      // Both masters always requesting: strict alternation from M0
      reset_dut();
      set_easy();
      dut_log.delete();
      auto_req = 1; p_req = 100;
      for (k = 0; k < 300 && dut_log.size() < 6; k++) step();
      chk("t3_grant_count", dut_log.size() >= 6, 1'b1);
      for (int i = 0; i < 6 && i < dut_log.size(); i++) chk("t3_grant_order", dut_log[i], exp_order[i]);
      auto_req = 0;
      wait_idle("t3_drain_timeout");

      // Slave AR stall: payload must hold, no new AR accepted
      step();
      auto_arrdy = 0; m_arready = 1'b0;
      set_req(1, 12'h5A4, 8'd0);
      step();
      set_req(0, 12'h111, 8'd0);
      for (int c = 0; c < 3; c++) begin
         step(); #3;
         chk("t4_ar_stable", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, {1'b1, 12'h5A4, 8'd0});
         chk("t4_arready_low", s_axi_arready, '0);
      end
      step();
      set_easy();
      wait_idle("t4_drain_timeout");

      // M1 stalls R mid-burst (len=3)
      step();
      set_easy();
      auto_rrdy = 0; s_rready = '0;
      sent.delete(); rcv.delete();
      set_req(1, 12'h300, 8'd3);
      got = 0; hold = 0;
      for (k = 0; k < 60 && rcv.size() < 4; k++) begin
         step();
         hold_now = (rcv.size() == 2 && hold < 2);
         if (hold_now) hold++;
         s_rready[1] = !hold_now;
         #3;
         if (hold_now) begin
            chk("t5_rready_low", m_axi_rready, 1'b0);
            chk("t5_beat_held", s_axi_rvalid, 2'b10);
         end
         if (s_axi_rvalid[1] && s_rready[1]) rcv.push_back(s_axi_rdata);
      end
      step();
      chk("t5_beat_count", rcv.size(), 4);
      for (int i = 0; i < 4 && i < rcv.size() && i < sent.size(); i++) chk("t5_beat_data", rcv[i], sent[i]);
      set_easy();
      wait_idle("t5_drain_timeout");

      // Reset during the second beat
      step();
      set_easy();
      set_req(1, 12'h480, 8'd3);
      got = 0;
      for (k = 0; k < 60 && got < 1; k++) begin
         step(); #3;
         if (s_axi_rvalid[1] && s_rready[1]) got++;
      end
      chk("t6_first_beat", got, 1);
      step();
      rst_n = 1'b0;
      clr_inputs();
      step();
      rst_n = 1'b1;
      #3;
      chk("t6_valids_after_reset", {m_axi_arvalid, s_axi_rvalid, m_axi_rready, s_axi_arready}, '0);
      step();
      set_req(0, 12'h010, 8'd0);
      set_req(1, 12'h020, 8'd0);
      #3;
      chk("t6_m0_wins", s_axi_arready, 2'b01);
      set_easy();
      wait_idle("t6_drain_timeout");

      // Random traffic with varying back-pressure and occasional resets
      for (int seg = 0; seg < 8; seg++) begin
         auto_req = 1;   p_req   = $urandom_range(10, 100);
         auto_rrdy = 1;  p_rrdy  = $urandom_range(20, 100);
         auto_arrdy = 1; p_arrdy = $urandom_range(20, 100);
         p_rvld = $urandom_range(20, 100);
         for (int c = 0; c < 500; c++) begin
            step();
            if ($urandom_range(599) == 0) reset_dut();
         end
      end
      auto_req = 0;
      set_easy();
      wait_idle("rand_drain_timeout");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
